wb_stage: RTL

- Final (writeback) stage of the pipelined RV32I core; sits directly upstream of the register file write port.
- Registers the MEM-stage result (MEM/WB pipeline register) and selects the writeback source: ALU result, aligned/extended load data, or PC+4.
- Drives the register file's rd write enable, address and data, and counts retired instructions (instret).
- Reports load alignment and encoding faults to the trap logic.

---
 rtl/wb_stage.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// ============================================================================
// wb_stage -- writeback stage of the pipelined RV32I core
//
// Holds the MEM/WB pipeline register and turns its contents into the register
// file write port, the retire strobe and the instret counter. Load data is
// aligned and sign/zero extended here, and load alignment / encoding faults are
// reported to the trap logic.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_valid                MEM stage presents a valid instruction
//   i_stall                hold the WB register contents
//   i_flush                turn the WB register into a bubble (beats stall)
//   i_rd_wen, i_rd_waddr   destination write request / register index
//   i_sel                  source select: 00 ALU, 01 load, 10 PC+4, 11 reserved
//   i_funct3, i_addr_lo    load type and byte offset of the load address
//   i_alu_result           ALU result
//   i_load_word            raw 32-bit word from data memory
//   i_pc_plus4             link value
//   o_rd_wen/waddr/wdata   register file write port
//   o_retire               one-cycle pulse per retired instruction
//   o_misalign, o_illegal  load misalignment / reserved encoding fault
//   o_instret              retired-instruction count (wraps)
// ============================================================================
module wb_stage #(
    parameter int INSTRET_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_rd_wen,
    input  logic [4:0]           i_rd_waddr,
    input  logic [1:0]           i_sel,
    input  logic [2:0]           i_funct3,
    input  logic [1:0]           i_addr_lo,
    input  logic [31:0]          i_alu_result,
    input  logic [31:0]          i_load_word,
    input  logic [31:0]          i_pc_plus4,
    output logic                 o_rd_wen,
    output logic [4:0]           o_rd_waddr,
    output logic [31:0]          o_rd_wdata,
    output logic                 o_retire,
    output logic                 o_misalign,
    output logic                 o_illegal,
    output logic [INSTRET_W-1:0] o_instret
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Load helpers
    // ------------------------------------------------------------------

    // Align the addressed byte/half of the memory word and extend it.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  f3,
        input logic [1:0]  lo,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lo, 3'b000});
        h = 16'(word >> {lo[1], 4'b0000});
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LW:   r = word;
            F3_LBU:  r = {24'h000000, b};
            F3_LHU:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Alignment fault for a legal load encoding.
    function automatic logic load_misaligned(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic m;
        case (f3)
            F3_LH, F3_LHU: m = lo[0];
            F3_LW:         m = (lo != 2'b00);
            default:       m = 1'b0;
        endcase
        return m;
    endfunction

    // funct3 values with no defined load.
    function automatic logic load_f3_reserved(input logic [2:0] f3);
        logic r;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: r = 1'b0;
            default:                             r = 1'b1;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic        valid_r;
    logic        committed_r;   // entry already had its commit cycle while stalled
    logic        rd_wen_r;
    logic [4:0]  rd_waddr_r;
    logic [1:0]  sel_r;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] alu_r;
    logic [31:0] load_word_r;
    logic [31:0] pc_plus4_r;
    logic [INSTRET_W-1:0] instret_r;

    // Pipeline register update: flush beats stall, stall holds the fields.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_r     <= 1'b0;
            committed_r <= 1'b0;
            rd_wen_r    <= 1'b0;
            rd_waddr_r  <= 5'd0;
            sel_r       <= 2'b00;
            funct3_r    <= 3'b000;
            addr_lo_r   <= 2'b00;
            alu_r       <= 32'h0000_0000;
            load_word_r <= 32'h0000_0000;
            pc_plus4_r  <= 32'h0000_0000;
        end else if (i_flush) begin
            valid_r     <= 1'b0;
            committed_r <= 1'b0;
        end else if (i_stall) begin
            // Once a valid entry has sat through a cycle it has committed;
            // the remaining stalled cycles must not write or count again.
            committed_r <= committed_r | valid_r;
        end else begin
            valid_r     <= i_valid;
            committed_r <= 1'b0;
            rd_wen_r    <= i_rd_wen;
            rd_waddr_r  <= i_rd_waddr;
            sel_r       <= i_sel;
            funct3_r    <= i_funct3;
            addr_lo_r   <= i_addr_lo;
            alu_r       <= i_alu_result;
            load_word_r <= i_load_word;
            pc_plus4_r  <= i_pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Commit, fault and writeback decode
    // ------------------------------------------------------------------
    logic        commit_s;
    logic        misalign_s;
    logic        illegal_s;
    logic        fault_s;
    logic        retire_s;
    logic        wen_s;
    logic [31:0] wdata_s;

    // Writeback data mux and commit-qualified strobes.
    always_comb begin
        wdata_s    = 32'h0000_0000;
        misalign_s = 1'b0;
        illegal_s  = 1'b0;
        commit_s   = valid_r & ~committed_r;

        case (sel_r)
            SEL_ALU:  wdata_s = alu_r;
            SEL_LOAD: wdata_s = load_extract(funct3_r, addr_lo_r, load_word_r);
            SEL_LINK: wdata_s = pc_plus4_r;
            default:  wdata_s = 32'h0000_0000;
        endcase

        if (sel_r == SEL_LOAD) begin
            misalign_s = commit_s & load_misaligned(funct3_r, addr_lo_r);
            illegal_s  = commit_s & load_f3_reserved(funct3_r);
        end else if (sel_r == SEL_LINK || sel_r == SEL_ALU) begin
            misalign_s = 1'b0;
            illegal_s  = 1'b0;
        end else begin
            misalign_s = 1'b0;
            illegal_s  = commit_s;
        end

        fault_s  = misalign_s | illegal_s;
        retire_s = commit_s & ~fault_s;
        wen_s    = retire_s & rd_wen_r & (rd_waddr_r != 5'd0);
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + INSTRET_ONE;
        end
    end

    assign o_rd_wen   = wen_s;
    assign o_rd_waddr = rd_waddr_r;
    assign o_rd_wdata = wdata_s;
    assign o_retire   = retire_s;
    assign o_misalign = misalign_s;
    assign o_illegal  = illegal_s;
    assign o_instret  = instret_r;

endmodule
